// File: rtl/clk_phase_pkg.sv
// Shared constants for the 1H/2H/4H phase generator: default parameters and FSM state encoding.
package clk_phase_pkg;

  localparam int unsigned N_TAPS_DEF      = 4;
  localparam int unsigned HOLD_CYCLES_DEF = 31;
  localparam int unsigned CNT_W_DEF       = 8;

  // State encoding (HOLD, RUN), kept as plain constants for legacy compatibility
  typedef logic [0:0] state_t;
  localparam state_t ST_HOLD = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/phase_checker.sv
// Watches the sampled 2H/4H timing bits and raises a sticky error on any phase violation.
// 2H must toggle every cycle; 4H must alternate toggle / no-toggle.
module phase_checker
  import clk_phase_pkg::*;
(
  input  logic CLK_1H,
  input  logic reset2,
  input  logic soft_rst,
  input  logic CLK_2H,
  input  logic CLK_4H,
  output logic phase_err,
  output logic viol_c
);

  logic       prev_2h_q, prev_4h_q;
  logic       tog4_q;
  logic [1:0] hist_q, hist_d;
  logic       perr_q, perr_d;
  logic       tog2_c, tog4_c, armed_c;

  // Violation detect against stored history; silent until two valid samples exist
  always_comb begin
    tog2_c  = CLK_2H ^ prev_2h_q;
    tog4_c  = CLK_4H ^ prev_4h_q;
    armed_c = (hist_q == 2'd2);
    viol_c  = armed_c & (~tog2_c | (tog4_c == tog4_q));
  end

  // History depth and sticky flag next-state; soft restart disarms and clears
  always_comb begin
    hist_d = hist_q;
    perr_d = perr_q;
    if (soft_rst) begin
      hist_d = 2'd0;
      perr_d = 1'b0;
    end else begin
      if (hist_q != 2'd2) hist_d = hist_q + 2'd1;
      perr_d = perr_q | viol_c;
    end
  end

  // Sample registers
  always_ff @(posedge CLK_1H or posedge reset2) begin
    if (reset2) begin
      prev_2h_q <= 1'b0;
      prev_4h_q <= 1'b0;
      tog4_q    <= 1'b0;
      hist_q    <= 2'd0;
      perr_q    <= 1'b0;
    end else begin
      prev_2h_q <= CLK_2H;
      prev_4h_q <= CLK_4H;
      tog4_q    <= tog4_c;
      hist_q    <= hist_d;
      perr_q    <= perr_d;
    end
  end

  assign phase_err = perr_q;

endmodule

// File: rtl/clk_phase_gen.sv
// CLK_4H delay taps, delayed 2H, post-reset hold sequencer and phase checking.
// Optional macro PHASE_RESYNC_EN: a phase violation seen in RUN also restarts the hold.
module clk_phase_gen
  import clk_phase_pkg::*;
#(
  parameter int unsigned N_TAPS      = N_TAPS_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              CLK_1H,
  input  logic              reset2,
  input  logic              CLK_2H,
  input  logic              CLK_4H,
  input  logic              soft_rst,
  output logic              CLK_2HDL,
  output logic [N_TAPS-1:0] tap,
  output logic [N_TAPS-1:0] tap_b,
  output logic              sys_run,
  output logic              phase_err,
  output logic [CNT_W-1:0]  hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_CYCLES);

  logic [N_TAPS-1:0] tap_q;
  logic              dl2_q;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef PHASE_RESYNC_EN
  logic              viol_c;
`endif

  phase_checker u_chk (
    .CLK_1H    (CLK_1H),
    .reset2    (reset2),
    .soft_rst  (soft_rst),
    .CLK_2H    (CLK_2H),
    .CLK_4H    (CLK_4H),
    .phase_err (phase_err),
`ifdef PHASE_RESYNC_EN
    .viol_c    (viol_c)
`else
    .viol_c    ()
`endif
  );

  // Delay chain: free-running in every state, independent of errors
  always_ff @(posedge CLK_1H or posedge reset2) begin
    if (reset2) begin
      tap_q <= '0;
      dl2_q <= 1'b0;
    end else begin
      tap_q <= {tap_q[N_TAPS-2:0], CLK_4H};
      dl2_q <= CLK_2H;
    end
  end

  // Hold/run sequencer next-state; soft restart overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (soft_rst) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RUN;
            cnt_d   = HOLD_SAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
`ifdef PHASE_RESYNC_EN
          if (viol_c) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
`endif
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge CLK_1H or posedge reset2) begin
    if (reset2) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tap      = tap_q;
  assign tap_b    = ~tap_q;
  assign CLK_2HDL = dl2_q;
  assign sys_run  = (state_q == ST_RUN);
  assign hold_cnt = cnt_q;

endmodule

// File: tb/tb_clk_phase_gen.sv
// Directed bench for clk_phase_gen: tap table, hold timing, phase errors, soft/async restart.
module tb_clk_phase_gen;

  logic       clk;
  logic       reset2;
  logic       c2, c4, srst;

  logic       dl2, sr, pe;
  logic [5:0] tap, tap_b;
  logic [7:0] cnt;

  logic       dl2_1, sr_1, pe_1;
  logic [3:0] tap_1, tap_b_1;
  logic [7:0] cnt_1;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic       c2h;
    logic       c4h;
    logic [5:0] tap;
    logic       dl2;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [12];

  clk_phase_gen #(.N_TAPS(6), .HOLD_CYCLES(31), .CNT_W(8)) dut (
    .CLK_1H(clk), .reset2(reset2), .CLK_2H(c2), .CLK_4H(c4), .soft_rst(srst),
    .CLK_2HDL(dl2), .tap(tap), .tap_b(tap_b), .sys_run(sr), .phase_err(pe),
    .hold_cnt(cnt)
  );

  clk_phase_gen #(.N_TAPS(4), .HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .CLK_1H(clk), .reset2(reset2), .CLK_2H(c2), .CLK_4H(c4), .soft_rst(srst),
    .CLK_2HDL(dl2_1), .tap(tap_1), .tap_b(tap_b_1), .sys_run(sr_1), .phase_err(pe_1),
    .hold_cnt(cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic a2, input logic a4, input logic s);
    c2   = a2;
    c4   = a4;
    srst = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic exp_sr, input logic exp_pe,
                     input logic [7:0] exp_cnt);
    n_vec++;
    if (sr !== exp_sr || pe !== exp_pe || cnt !== exp_cnt) begin
      n_miss++;
      $display("FAIL %s: sys_run=%b want %b, phase_err=%b want %b, hold_cnt=%0d want %0d",
               name, sr, exp_sr, pe, exp_pe, cnt, exp_cnt);
    end
  endtask

  task automatic chk_reset(input string name);
    n_vec++;
    if (tap !== 6'h00 || tap_b !== 6'h3F || dl2 !== 1'b0 || sr !== 1'b0 ||
        pe !== 1'b0 || cnt !== 8'd0) begin
      n_miss++;
      $display("FAIL %s: tap=%b tap_b=%b 2hdl=%b sys_run=%b phase_err=%b hold_cnt=%0d want 000000 111111 0 0 0 0",
               name, tap, tap_b, dl2, sr, pe, cnt);
    end
    n_vec++;
    if (tap_1 !== 4'h0 || tap_b_1 !== 4'hF || dl2_1 !== 1'b0 || sr_1 !== 1'b0 ||
        pe_1 !== 1'b0 || cnt_1 !== 8'd0) begin
      n_miss++;
      $display("FAIL %s_h1: tap=%b tap_b=%b 2hdl=%b sys_run=%b phase_err=%b hold_cnt=%0d want 0000 1111 0 0 0 0",
               name, tap_1, tap_b_1, dl2_1, sr_1, pe_1, cnt_1);
    end
  endtask

  initial begin
    logic [7:0] g, a, b;
    logic [5:0] etb;

    // free-running counter c: CLK_2H = c[0], CLK_4H = c[1]; entry i is the (i+1)th edge
    tbl[0]  = '{1'b0, 1'b0, 6'b000000, 1'b0, 8'd1};
    tbl[1]  = '{1'b1, 1'b0, 6'b000000, 1'b1, 8'd2};
    tbl[2]  = '{1'b0, 1'b1, 6'b000001, 1'b0, 8'd3};
    tbl[3]  = '{1'b1, 1'b1, 6'b000011, 1'b1, 8'd4};
    tbl[4]  = '{1'b0, 1'b0, 6'b000110, 1'b0, 8'd5};
    tbl[5]  = '{1'b1, 1'b0, 6'b001100, 1'b1, 8'd6};
    tbl[6]  = '{1'b0, 1'b1, 6'b011001, 1'b0, 8'd7};
    tbl[7]  = '{1'b1, 1'b1, 6'b110011, 1'b1, 8'd8};
    tbl[8]  = '{1'b0, 1'b0, 6'b100110, 1'b0, 8'd9};
    tbl[9]  = '{1'b1, 1'b0, 6'b001100, 1'b1, 8'd10};
    tbl[10] = '{1'b0, 1'b1, 6'b011001, 1'b0, 8'd11};
    tbl[11] = '{1'b1, 1'b1, 6'b110011, 1'b1, 8'd12};

    c2 = 1'b0; c4 = 1'b0; srst = 1'b0;
    reset2 = 1'b0;
    #1 reset2 = 1'b1;
    #2 chk_reset("por_reset");

    @(posedge clk);
    #1 reset2 = 1'b0;

    n_vec++;
    if (sr_1 !== 1'b0) begin
      n_miss++;
      $display("FAIL h1_release: sys_run=%b want 0", sr_1);
    end

    // tap chain / 2H delay table, hold counter running alongside
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].c2h, tbl[i].c4h, 1'b0);
      etb = ~tbl[i].tap;
      n_vec++;
      if (tap !== tbl[i].tap || tap_b !== etb || dl2 !== tbl[i].dl2 ||
          cnt !== tbl[i].cnt || sr !== 1'b0 || pe !== 1'b0) begin
        n_miss++;
        $display("FAIL tbl[%0d]: tap=%b/%b tap_b=%b/%b 2hdl=%b/%b cnt=%0d/%0d sys_run=%b/0 phase_err=%b/0",
                 i, tap, tbl[i].tap, tap_b, etb, dl2, tbl[i].dl2, cnt, tbl[i].cnt, sr, pe);
      end
      if (i < 2) begin
        n_vec++;
        if (sr_1 !== 1'b1 || cnt_1 !== 8'd1) begin
          n_miss++;
          $display("FAIL h1_run[%0d]: sys_run=%b want 1, hold_cnt=%0d want 1", i, sr_1, cnt_1);
        end
      end
    end

    // remainder of the 31-cycle hold and early RUN
    for (int e = 13; e <= 40; e++) begin
      g = 8'(e - 1);
      step(g[0], g[1], 1'b0);
      chk("hold_run", (e >= 31), 1'b0, (e >= 31) ? 8'd31 : 8'(e));
    end

    // soft restart in RUN coinciding with a missed 2H toggle
    step(1'b1, 1'b0, 1'b1);
    chk("srst_glitch", 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("srst_disarmed", 1'b0, 1'b0, 8'd1);
    for (int k = 0; k < 16; k++) begin
      a = 8'(k);
      b = 8'(k + 1);
      step(a[0], b[1], 1'b0);
      chk("srst_rearm", 1'b0, 1'b0, 8'(k + 2));
    end

    // async reset between edges with hold_cnt at 17
    #2 reset2 = 1'b1;
    #1 chk_reset("async_mid_hold");
    @(posedge clk);
    #1 reset2 = 1'b0;
    for (int e = 1; e <= 34; e++) begin
      g = 8'(e - 1);
      step(g[0], g[1], 1'b0);
      chk("rehold", (e >= 31), 1'b0, (e >= 31) ? 8'd31 : 8'(e));
    end

    // CLK_4H held low for three cycles while in RUN
    step(1'b0, 1'b0, 1'b0);
`ifdef PHASE_RESYNC_EN
    chk("viol_1", 1'b0, 1'b1, 8'd0);
`else
    chk("viol_1", 1'b1, 1'b1, 8'd31);
`endif
    step(1'b1, 1'b0, 1'b0);
`ifdef PHASE_RESYNC_EN
    chk("viol_2", 1'b0, 1'b1, 8'd1);
`else
    chk("viol_2", 1'b1, 1'b1, 8'd31);
`endif
    step(1'b0, 1'b0, 1'b0);
`ifdef PHASE_RESYNC_EN
    chk("viol_3", 1'b0, 1'b1, 8'd2);
`else
    chk("viol_3", 1'b1, 1'b1, 8'd31);
`endif
    step(1'b1, 1'b1, 1'b0);
`ifdef PHASE_RESYNC_EN
    chk("viol_sticky", 1'b0, 1'b1, 8'd3);
`else
    chk("viol_sticky", 1'b1, 1'b1, 8'd31);
`endif

    // soft restart clears the sticky flag
    step(1'b0, 1'b1, 1'b1);
    chk("srst_clear", 1'b0, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
